// File: rtl/tilemap_addr_gen.sv
// tilemap_addr_gen: screen position counters, CPU scroll/priority register bank
// and a time-sliced tilemap fetch sequencer feeding character-ROM addresses for
// NUM_LAYERS scroll layers. Each layer's tile is fetched one tile ahead of display.
module tilemap_addr_gen #(
  parameter int NUM_LAYERS    = 2,
  parameter int TILE_LOG2     = 3,
  parameter int MAP_COLS_LOG2 = 6,
  parameter int MAP_ROWS_LOG2 = 5,
  parameter int HSCROLL_W     = 9,
  parameter int VSCROLL_W     = 8,
  parameter int ATTR_W        = 2,
  localparam int LW   = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1,
  localparam int RA_W = LW + MAP_ROWS_LOG2 + MAP_COLS_LOG2 + 1,
  localparam int GA_W = ATTR_W + 8 + TILE_LOG2
) (
  input  logic                    CLK_6M,
  input  logic                    rst,
  input  logic                    nHSYNC,
  input  logic                    nVSYNC,
  input  logic                    FLIP,
  input  logic                    nLATCH,
  input  logic [LW+1:0]           CA,
  input  logic [7:0]              CD,
  output logic [RA_W-1:0]         RA,
  input  logic [7:0]              RD,
  output logic [GA_W-1:0]         GA,
  output logic [LW-1:0]           GA_LAYER,
  output logic                    GA_STB,
  output logic [NUM_LAYERS-1:0]   TILE_LOAD,
  output logic [3*NUM_LAYERS-1:0] PRI
);

  // Every layer needs two RAM slots plus one spare slot inside a single tile period.
  if (2 * NUM_LAYERS + 1 > (1 << TILE_LOG2)) begin : g_slot_check
    $fatal(1, "tilemap_addr_gen: 2*NUM_LAYERS+1 fetch slots do not fit in one tile");
  end

  localparam logic [HSCROLL_W-1:0] TILE_POS = HSCROLL_W'(1 << TILE_LOG2);
  localparam logic [HSCROLL_W-1:0] TILE_NEG = HSCROLL_W'(-(1 << TILE_LOG2));

  logic [HSCROLL_W-1:0]     hcount;
  logic [VSCROLL_W-1:0]     vcount;
  logic                     hsync_q;
  logic                     vsync_q;
  logic                     hfall;
  logic                     vfall;

  logic [HSCROLL_W-1:0]     hscroll [NUM_LAYERS];
  logic [VSCROLL_W-1:0]     vscroll [NUM_LAYERS];
  logic [LW-1:0]            wr_layer;

  logic [HSCROLL_W-1:0]     xs;
  logic [VSCROLL_W-1:0]     ys;
  logic [TILE_LOG2-1:0]     slot;
  logic [LW-1:0]            fetch_layer;
  logic                     fetch_byte;
  logic                     fetch_active;
  logic [HSCROLL_W-1:0]     hsel;
  logic [VSCROLL_W-1:0]     vsel;
  logic [HSCROLL_W-1:0]     look_x;
  logic [VSCROLL_W-1:0]     look_y;
  logic [MAP_COLS_LOG2-1:0] col;
  logic [MAP_ROWS_LOG2-1:0] row;
  logic [TILE_LOG2-1:0]     fine_y;
  logic [RA_W-1:0]          ra_next;
  logic [NUM_LAYERS-1:0]    tile_edge;

  logic                     pend_vld;
  logic                     pend_b;
  logic [LW-1:0]            pend_l;
  logic [TILE_LOG2-1:0]     pend_fy;
  logic [7:0]               index_q;

  assign hfall    = hsync_q & ~nHSYNC;
  assign vfall    = vsync_q & ~nVSYNC;
  assign wr_layer = CA[LW+1:2];

  // Pixel/line counters: HSYNC fall starts a new line, VSYNC fall restarts the frame.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      hcount  <= '0;
      vcount  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= nHSYNC;
      vsync_q <= nVSYNC;
      if (hfall) begin
        hcount <= '0;
        vcount <= vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
      if (vfall) begin
        vcount <= '0;
      end
    end
  end

  // CPU register bank: scroll and priority per layer, written on every low nLATCH clock.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        hscroll[l] <= '0;
        vscroll[l] <= '0;
      end
      PRI <= '0;
    end else if (!nLATCH) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (wr_layer == LW'(l)) begin
          case (CA[1:0])
            2'd0: hscroll[l][7:0] <= CD;
            2'd1: begin
              hscroll[l][8]  <= CD[0];
              PRI[3*l +: 3]  <= CD[3:1];
            end
            2'd2: vscroll[l] <= VSCROLL_W'(CD);
            default: ;
          endcase
        end
      end
    end
  end

  assign xs           = FLIP ? ~hcount : hcount;
  assign ys           = FLIP ? ~vcount : vcount;
  assign slot         = hcount[TILE_LOG2-1:0];
  assign fetch_layer  = LW'(slot >> 1);
  assign fetch_byte   = slot[0];
  assign fetch_active = (32'(slot) < 32'(2 * NUM_LAYERS)) && !hfall;

  // Pick the scroll registers of the layer owning the current fetch slot.
  always_comb begin
    hsel = '0;
    vsel = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (fetch_layer == LW'(l)) begin
        hsel = hscroll[l];
        vsel = vscroll[l];
      end
    end
  end

  assign look_x  = xs + hsel + (FLIP ? TILE_NEG : TILE_POS);
  assign look_y  = ys + vsel;
  assign col     = MAP_COLS_LOG2'(look_x >> TILE_LOG2);
  assign row     = MAP_ROWS_LOG2'(look_y >> TILE_LOG2);
  assign fine_y  = look_y[TILE_LOG2-1:0];
  assign ra_next = {fetch_layer, row, col, fetch_byte};

  // A layer crosses a tile boundary when its scrolled x has zero fine bits.
  always_comb begin
    tile_edge = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      tile_edge[l] = (xs[TILE_LOG2-1:0] + hscroll[l][TILE_LOG2-1:0]) == '0;
    end
  end

  // Fetch sequencer: issue RA, then one cycle later capture RD as index or emit GA.
  // A line restart drops whatever is in flight so a half-fetched layer never strobes.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      RA        <= '0;
      GA        <= '0;
      GA_LAYER  <= '0;
      GA_STB    <= 1'b0;
      TILE_LOAD <= '0;
      pend_vld  <= 1'b0;
      pend_b    <= 1'b0;
      pend_l    <= '0;
      pend_fy   <= '0;
      index_q   <= '0;
    end else begin
      GA_STB    <= 1'b0;
      TILE_LOAD <= tile_edge;
      if (fetch_active) begin
        RA <= ra_next;
      end
      pend_vld <= fetch_active;
      pend_b   <= fetch_byte;
      pend_l   <= fetch_layer;
      pend_fy  <= fine_y;
      if (pend_vld && !hfall) begin
        if (!pend_b) begin
          index_q <= RD;
        end else begin
          GA       <= {RD[ATTR_W-1:0], index_q, pend_fy};
          GA_LAYER <= pend_l;
          GA_STB   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tilemap_addr_gen.sv
// tb_tilemap_addr_gen: randomized bench with a per-cycle reference model of the
// counters, scroll bank and fetch schedule; a scoreboard monitor checks the DUT.
module tb_tilemap_addr_gen;

  localparam int NL = 2;

  bit          CLK_6M;
  logic        rst;
  logic        nHSYNC;
  logic        nVSYNC;
  logic        FLIP;
  logic        nLATCH;
  logic [2:0]  CA;
  logic [7:0]  CD;
  logic [12:0] RA;
  logic [7:0]  RD;
  logic [12:0] GA;
  logic [0:0]  GA_LAYER;
  logic        GA_STB;
  logic [1:0]  TILE_LOAD;
  logic [5:0]  PRI;

  logic [7:0]  mem [0:8191];

  typedef struct {
    int ra;
    int tl;
    int pri;
    bit stb;
    bit inRst;
  } cycExp_t;

  typedef struct {
    int ga;
    int layer;
  } gaExp_t;

  cycExp_t cycQ[$];
  gaExp_t  gaQ[$];

  int vectors;
  int miscompares;

  int mH, mV, mRa, runLen, aPrev1, aPrev2, fyPrev1;
  bit mHsd, mVsd;
  int mHs[NL];
  int mVs[NL];
  int mPri[NL];
  bit curFlip;

  tilemap_addr_gen #(
    .NUM_LAYERS(2), .TILE_LOG2(3), .MAP_COLS_LOG2(6), .MAP_ROWS_LOG2(5),
    .HSCROLL_W(9), .VSCROLL_W(8), .ATTR_W(2)
  ) dut (
    .CLK_6M(CLK_6M), .rst(rst), .nHSYNC(nHSYNC), .nVSYNC(nVSYNC), .FLIP(FLIP),
    .nLATCH(nLATCH), .CA(CA), .CD(CD), .RA(RA), .RD(RD), .GA(GA),
    .GA_LAYER(GA_LAYER), .GA_STB(GA_STB), .TILE_LOAD(TILE_LOAD), .PRI(PRI)
  );

  assign RD = mem[RA];

  always #5 CLK_6M = ~CLK_6M;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: model the edge from the rules, queue expectations, then clock.
  task automatic applyStimulus(input bit r, input bit nh, input bit nv, input bit fl,
                               input bit nl, input int ca, input int cd);
    cycExp_t e;
    gaExp_t  g;
    bit hf, vf;
    int s, xs, ys, x, y, lay, sel, a, fy;
    rst = r; nHSYNC = nh; nVSYNC = nv; FLIP = fl; nLATCH = nl;
    CA = 3'(ca); CD = 8'(cd);
    e.ra = 0; e.tl = 0; e.pri = 0; e.stb = 0; e.inRst = 0;
    if (r) begin
      mH = 0; mV = 0; mHsd = 1; mVsd = 1; mRa = 0; runLen = 0;
      aPrev1 = 0; aPrev2 = 0; fyPrev1 = 0;
      for (int l = 0; l < NL; l++) begin
        mHs[l] = 0; mVs[l] = 0; mPri[l] = 0;
      end
      e.inRst = 1;
    end else begin
      hf = mHsd && !nh;
      vf = mVsd && !nv;
      s  = mH & 7;
      xs = fl ? (~mH & 511) : mH;
      ys = fl ? (~mV & 255) : mV;
      a  = -1;
      fy = 0;
      if (s < 2 * NL) begin
        lay = s >> 1;
        x   = (xs + mHs[lay] + (fl ? -8 : 8)) & 511;
        y   = (ys + mVs[lay]) & 255;
        a   = ((lay * 32 + ((y >> 3) & 31)) * 64 + ((x >> 3) & 63)) * 2 + (s & 1);
        fy  = y & 7;
      end
      if (!hf && runLen >= 2 && s >= 2 && s <= 2 * NL && (s % 2) == 0) begin
        e.stb   = 1;
        g.ga    = ((int'(mem[aPrev1]) & 3) << 11) | (int'(mem[aPrev2]) << 3) | fyPrev1;
        g.layer = (s - 2) / 2;
        gaQ.push_back(g);
      end
      if (!hf && a >= 0) mRa = a;
      aPrev2  = aPrev1;
      aPrev1  = a;
      fyPrev1 = fy;
      runLen  = hf ? 0 : runLen + 1;
      for (int l = 0; l < NL; l++) begin
        if (((xs + mHs[l]) & 7) == 0) e.tl |= (1 << l);
      end
      if (!nl) begin
        lay = ca >> 2;
        sel = ca & 3;
        if (lay < NL) begin
          if (sel == 0) mHs[lay] = (mHs[lay] & 256) | (cd & 255);
          if (sel == 1) begin
            mHs[lay]  = (mHs[lay] & 255) | ((cd & 1) << 8);
            mPri[lay] = (cd >> 1) & 7;
          end
          if (sel == 2) mVs[lay] = cd & 255;
        end
      end
      mHsd = nh;
      mVsd = nv;
      if (hf) begin
        mH = 0;
        mV = (mV + 1) & 255;
      end else begin
        mH = (mH + 1) & 511;
      end
      if (vf) mV = 0;
    end
    e.ra = mRa;
    for (int l = 0; l < NL; l++) e.pri |= mPri[l] << (3 * l);
    cycQ.push_back(e);
    @(posedge CLK_6M);
    @(negedge CLK_6M);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b1, curFlip, 1'b1, 0, 0);
  endtask

  task automatic cpuWrite(input int ca, input int cd);
    applyStimulus(1'b0, 1'b1, 1'b1, curFlip, 1'b0, ca, cd);
  endtask

  task automatic lineStart(input bit withVsync);
    applyStimulus(1'b0, 1'b0, !withVsync, curFlip, 1'b1, 0, 0);
  endtask

  // Scoreboard monitor: every cycle's outputs, plus a GA pop whenever the DUT strobes.
  cycExp_t monE;
  gaExp_t  monG;
  always @(negedge CLK_6M) begin
    if (cycQ.size() > 0) begin
      monE = cycQ.pop_front();
      checkOutput("RA", 32'(RA), 32'(monE.ra));
      checkOutput("TILE_LOAD", 32'(TILE_LOAD), 32'(monE.tl));
      checkOutput("PRI", 32'(PRI), 32'(monE.pri));
      checkOutput("GA_STB", 32'(GA_STB), 32'(monE.stb));
      if (monE.inRst) begin
        checkOutput("GA_reset", 32'(GA), 32'd0);
        checkOutput("GA_LAYER_reset", 32'(GA_LAYER), 32'd0);
      end
      if (GA_STB === 1'b1) begin
        if (gaQ.size() == 0) begin
          checkOutput("GA_unexpected", 32'(GA_STB), 32'd0);
        end else begin
          monG = gaQ.pop_front();
          checkOutput("GA", 32'(GA), 32'(monG.ga));
          checkOutput("GA_LAYER", 32'(GA_LAYER), 32'(monG.layer));
        end
      end
    end
  end

  // Directed scenarios first, then a long randomized run with mid-line syncs and resets.
  initial begin
    vectors = 0;
    miscompares = 0;
    curFlip = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h086] = 8'h5A;
    mem[13'h087] = 8'h02;

    repeat (3) applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));

    cpuWrite(4, 'h23);
    cpuWrite(5, 'h07);
    idle(6);
    cpuWrite(4, 'h00);
    cpuWrite(5, 'h06);

    lineStart(1'b1);
    idle(3);
    repeat (10) begin
      lineStart(1'b0);
      idle(30);
    end

    curFlip = 1;
    lineStart(1'b1);
    idle(12);
    curFlip = 0;

    cpuWrite(0, 'hFC);
    cpuWrite(1, 'h01);
    lineStart(1'b0);
    idle(20);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) curFlip = !curFlip;
      if ($urandom_range(0, 699) == 0) begin
        applyStimulus(1'b1, 1'b1, 1'b1, curFlip, 1'b1, 0, 0);
      end else begin
        applyStimulus(1'b0,
                      !($urandom_range(0, 39) == 0),
                      !($urandom_range(0, 399) == 0),
                      curFlip,
                      !($urandom_range(0, 11) == 0),
                      int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 255)));
      end
    end
    idle(4);

    checkOutput("cycQ_drained", 32'(cycQ.size()), 32'd0);
    checkOutput("gaQ_drained", 32'(gaQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
